cmos_nvram_arbiter: RTL and testbench
=====================================

Name: cmos_nvram_arbiter

Overview:
- Shares the Williams-2 battery-backed CMOS RAM (1K x 4, high scores and settings) between the game CPU and the HPS ioctl load/save channel.
- Owns the single RAM port. It pauses the CPU, waits for the pause to settle, hands the port to the HPS, then returns the port to the CPU.
- Also sequences a full-RAM clear for the OSD "High Score Reset" command.
- Sits in the top level between hps_io and the williams2 core.

Parameters:
- ADDR_W, 10: RAM address width (1024 locations).
- DATA_W, 4: RAM data width (nibble).
- NV_INDEX, 4: ioctl_index value that selects the NVRAM file.
- PAUSE_CYCLES, 8: settle cycles after asserting cpu_pause before the port is taken (range 1..255).
- CLEAR_VAL, 4'hF: value written to every location during a clear.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_din  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write strobe (single cycle).
- cpu_dout  out  DATA_W  CPU read data.
- cpu_pause  out  1  halts the CPU while high.
- ioctl_download  in  1  HPS to core transfer active.
- ioctl_upload  in  1  core to HPS transfer active.
- ioctl_index  in  16  file index.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  download byte.
- ioctl_wr  in  1  download byte strobe.
- ioctl_rd  in  1  upload read strobe.
- ioctl_din  out  8  upload byte.
- ioctl_wait  out  1  stalls the HPS.
- clear_req  in  1  level input; a rising edge requests a clear.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DATA_W  RAM read data; synchronous RAM, 1-cycle read latency.
- busy  out  1  high in any state other than CPU.

Behaviour:
- Reset values: state CPU; cpu_pause=0, ioctl_wait=0, ioctl_din=0, busy=0, ram_we=0, settle and clear counters 0, stored clear_req level 0.
- hps_sel = (ioctl_download | ioctl_upload) & (ioctl_index == NV_INDEX).
- State CPU:
  - RAM port is combinationally routed from the CPU side: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we, cpu_dout=ram_dout.
  - hps_sel=1 → PAUSE.
  - clear_req rising edge (with hps_sel=0) → PAUSE, with clear pending.
  - If both occur in the same cycle, HPS wins and the clear request is dropped.
- State PAUSE:
  - cpu_pause=1, ram_we=0, ioctl_wait=1.
  - Counter counts PAUSE_CYCLES clocks, then → HPS or CLEAR.
- State HPS:
  - ram_addr = ioctl_addr[ADDR_W-1:0].
  - ioctl_wr → ram_we=1 in the same cycle, ram_din=ioctl_dout[3:0]. Upper nibble is ignored.
  - Strobes with ioctl_addr >= 2^ADDR_W produce no write.
  - ioctl_rd → ioctl_wait=1 for exactly 1 cycle. On the next cycle ioctl_din={4'h0,ram_dout} is registered and held until the next read.
  - hps_sel falling → RELEASE.
  - Reads and writes are completed in order; at most one strobe per cycle.
- State CLEAR:
  - Counter walks addresses 0..2^ADDR_W-1, one per clock, ram_we=1, ram_din=CLEAR_VAL.
  - After the last address (1024 cycles at the defaults) → RELEASE.
  - clear_req edges received during CLEAR are ignored.
  - hps_sel rising during CLEAR is stalled via ioctl_wait=1 until CLEAR finishes, then → HPS directly.
- State RELEASE:
  - ram_we=0, cpu_pause=1 for 1 cycle, then → CPU with cpu_pause=0.
- cpu_pause is registered; cpu_dout is ram_dout in all states (CPU is paused outside CPU state).
- Reset mid-operation: immediately returns to CPU state. Partial HPS or CLEAR writes are not rolled back.
- The clear_req edge detector is registered and reset to 0, so reset does not create a spurious edge.

Decomposition:
- Shared package williams2_pkg holds:
  - typedef nv_state_t {NV_CPU, NV_PAUSE, NV_HPS, NV_CLEAR, NV_RELEASE};
  - localparam NV_INDEX_DEFAULT=4 and CMOS_ADDR_W=10.
- One natural sub-module, nv_settle_counter: a loadable down-counter with a done pulse, reused for the PAUSE wait and the CLEAR walk.

Test Plan:
- Idle CPU access: cpu_we=1, addr 0x123, data 0xA; then read 0x123 → ram_we follows the CPU combinationally; cpu_dout=0xA one cycle after the address is presented; busy=0 throughout.
- NVRAM download: index 4, bytes 0x35,0x07 at addresses 0,1 → cpu_pause high; first write no earlier than 8 cycles after hps_sel; RAM[0]=5, RAM[1]=7; cpu_pause falls 2 cycles after ioctl_download falls.
- NVRAM upload: RAM[0x3FF]=0xC, ioctl_rd at addr 0x3FF → ioctl_wait high for 1 cycle; ioctl_din=0x0C on the following cycle.
- Non-NVRAM index: ioctl_index=0 download → cpu_pause stays 0; no ram_we from the HPS side.
- Clear: clear_req 0→1 → after 8 settle cycles, exactly 1024 consecutive ram_we cycles with ram_din=0xF across addresses 0..1023; then cpu_pause=0; a second edge during CLEAR causes no extra pass.
- Reset mid-clear: assert reset at clear address 100 → next edge in CPU state, cpu_pause=0; RAM[0..99]=0xF and RAM[100..] unchanged.

Source files
------------

// File: rtl/williams2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : williams2_pkg
// Purpose  : Shared types and constants for the Williams-2 CMOS NVRAM path.
// Revision : 1.0 - initial release
// ============================================================================
package williams2_pkg;

  // Owner of the single CMOS RAM port
  typedef enum logic [2:0] {
    NV_CPU     = 3'd0,
    NV_PAUSE   = 3'd1,
    NV_HPS     = 3'd2,
    NV_CLEAR   = 3'd3,
    NV_RELEASE = 3'd4
  } nv_state_t;

  localparam int NV_INDEX_DEFAULT = 4;
  localparam int CMOS_ADDR_W      = 10;
  localparam int CMOS_DATA_W      = 4;

endpackage
`default_nettype wire

// File: rtl/cmos_nvram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cmos_nvram_arbiter_if
// Purpose  : CPU, ioctl and RAM-port signals around the CMOS NVRAM arbiter.
//            slave = arbiter side, master = surrounding core / HPS / RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface cmos_nvram_arbiter_if
  import williams2_pkg::*;
#(
  parameter int ADDR_W = CMOS_ADDR_W,
  parameter int DATA_W = CMOS_DATA_W
) ();

  // CPU side
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_pause;

  // HPS ioctl side
  logic              ioctl_download;
  logic              ioctl_upload;
  logic [15:0]       ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wr;
  logic              ioctl_rd;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;

  // OSD clear command and status
  logic              clear_req;
  logic              busy;

  // Single RAM port
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  cpu_addr, cpu_din, cpu_we,
    input  ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
    input  ioctl_dout, ioctl_wr, ioctl_rd,
    input  clear_req, ram_dout,
    output cpu_dout, cpu_pause, ioctl_din, ioctl_wait,
    output ram_addr, ram_din, ram_we, busy
  );

  modport master (
    output cpu_addr, cpu_din, cpu_we,
    output ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
    output ioctl_dout, ioctl_wr, ioctl_rd,
    output clear_req, ram_dout,
    input  cpu_dout, cpu_pause, ioctl_din, ioctl_wait,
    input  ram_addr, ram_din, ram_we, busy
  );

endinterface
`default_nettype wire

// File: rtl/nv_settle_counter.sv
`default_nettype none
// ============================================================================
// Module   : nv_settle_counter
// Purpose  : Loadable down-counter; done is high while enabled at zero.
//            Used for the pause settle wait and for the clear address walk.
// Revision : 1.0 - initial release
// ============================================================================
module nv_settle_counter #(
  parameter int WIDTH = 10
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  input  wire logic             en,
  output logic      [WIDTH-1:0] count,
  output logic                  done
);

  // Load takes priority; otherwise count down to zero and hold there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = en && (count == '0);

endmodule
`default_nettype wire

// File: rtl/cmos_nvram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmos_nvram_arbiter
// Purpose  : Shares the 1K x 4 CMOS RAM between the game CPU and the HPS
//            ioctl load/save channel, and sequences the OSD high-score clear.
//            The CPU is paused and allowed to settle before the port moves.
// Revision : 1.0 - initial release
// ============================================================================
module cmos_nvram_arbiter
  import williams2_pkg::*;
#(
  parameter int                ADDR_W       = CMOS_ADDR_W,
  parameter int                DATA_W       = CMOS_DATA_W,
  parameter int                NV_INDEX     = NV_INDEX_DEFAULT,
  parameter int                PAUSE_CYCLES = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = 4'hF
) (
  input wire logic            clk_sys,
  input wire logic            reset,
  cmos_nvram_arbiter_if.slave bus
);

  // Shared counter must hold both the settle count and the top RAM address
  localparam int               CNT_W      = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'((1 << ADDR_W) - 1);

  nv_state_t        r_state;
  logic             r_clr_q;
  logic             r_clr_pend;
  logic             r_rd_pend;

  logic             w_hps_sel;
  logic             w_clear_rise;
  logic             w_addr_in_range;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_done;
  logic             unused_ioctl_hi;

  assign w_hps_sel = (bus.ioctl_download | bus.ioctl_upload) &
                     (bus.ioctl_index == 16'(NV_INDEX));
  assign w_clear_rise    = bus.clear_req & ~r_clr_q;
  assign w_addr_in_range = (bus.ioctl_addr[24:ADDR_W] == '0);
  assign w_cnt_en        = (r_state == NV_PAUSE) || (r_state == NV_CLEAR);
  assign unused_ioctl_hi = ^bus.ioctl_dout[7:DATA_W];

  // CPU is paused outside NV_CPU, so its read path can stay hard-wired
  assign bus.cpu_dout = bus.ram_dout;

  // Counter loads: settle count when leaving CPU, top address when starting a clear
  always_comb begin
    w_cnt_load     = 1'b0;
    w_cnt_load_val = PAUSE_LOAD;
    case (r_state)
      NV_CPU: begin
        w_cnt_load = w_hps_sel | w_clear_rise;
      end
      NV_PAUSE: begin
        if (w_cnt_done && r_clr_pend) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = CLEAR_LOAD;
        end
      end
      default: begin
      end
    endcase
  end

  nv_settle_counter #(
    .WIDTH (CNT_W)
  ) u_settle (
    .clk      (clk_sys),
    .rst      (reset),
    .load     (w_cnt_load),
    .load_val (w_cnt_load_val),
    .en       (w_cnt_en),
    .count    (w_cnt),
    .done     (w_cnt_done)
  );

  // RAM port mux; the clear walk counts down, so the address is its complement
  always_comb begin
    bus.ram_addr = bus.cpu_addr;
    bus.ram_din  = bus.cpu_din;
    bus.ram_we   = 1'b0;
    case (r_state)
      NV_CPU: begin
        bus.ram_we = bus.cpu_we;
      end
      NV_HPS: begin
        bus.ram_addr = bus.ioctl_addr[ADDR_W-1:0];
        bus.ram_din  = bus.ioctl_dout[DATA_W-1:0];
        bus.ram_we   = bus.ioctl_wr & w_addr_in_range;
      end
      NV_CLEAR: begin
        bus.ram_addr = ~w_cnt[ADDR_W-1:0];
        bus.ram_din  = CLEAR_VAL;
        bus.ram_we   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Port ownership FSM with registered pause, wait, read data and busy
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state        <= NV_CPU;
      r_clr_q        <= 1'b0;
      r_clr_pend     <= 1'b0;
      r_rd_pend      <= 1'b0;
      bus.cpu_pause  <= 1'b0;
      bus.ioctl_wait <= 1'b0;
      bus.ioctl_din  <= '0;
      bus.busy       <= 1'b0;
    end else begin
      r_clr_q <= bus.clear_req;
      case (r_state)
        NV_CPU: begin
          // HPS wins a simultaneous request; the clear edge is simply consumed
          if (w_hps_sel || w_clear_rise) begin
            r_state        <= NV_PAUSE;
            r_clr_pend     <= ~w_hps_sel;
            bus.cpu_pause  <= 1'b1;
            bus.ioctl_wait <= 1'b1;
            bus.busy       <= 1'b1;
          end
        end
        NV_PAUSE: begin
          if (w_cnt_done) begin
            if (r_clr_pend) begin
              r_state        <= NV_CLEAR;
              bus.ioctl_wait <= w_hps_sel;
            end else begin
              r_state        <= NV_HPS;
              bus.ioctl_wait <= 1'b0;
            end
          end
        end
        NV_HPS: begin
          // A read holds the HPS one cycle while the synchronous RAM answers
          r_rd_pend      <= 1'b0;
          bus.ioctl_wait <= 1'b0;
          if (r_rd_pend) begin
            bus.ioctl_din <= {{(8-DATA_W){1'b0}}, bus.ram_dout};
          end
          if (!w_hps_sel) begin
            r_state <= NV_RELEASE;
          end else if (bus.ioctl_rd && !r_rd_pend) begin
            r_rd_pend      <= 1'b1;
            bus.ioctl_wait <= 1'b1;
          end
        end
        NV_CLEAR: begin
          // An HPS transfer arriving mid-clear is stalled, then served directly
          bus.ioctl_wait <= w_hps_sel;
          if (w_cnt_done) begin
            r_clr_pend     <= 1'b0;
            bus.ioctl_wait <= 1'b0;
            r_state        <= w_hps_sel ? NV_HPS : NV_RELEASE;
          end
        end
        NV_RELEASE: begin
          r_state       <= NV_CPU;
          bus.cpu_pause <= 1'b0;
          bus.busy      <= 1'b0;
        end
        default: begin
          r_state        <= NV_CPU;
          r_clr_pend     <= 1'b0;
          bus.cpu_pause  <= 1'b0;
          bus.ioctl_wait <= 1'b0;
          bus.busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmos_nvram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_nvram_arbiter
// Purpose  : Directed table-driven bench for cmos_nvram_arbiter with a
//            behavioural 1K x 4 synchronous RAM on the arbitrated port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_nvram_arbiter;

  logic clk_sys = 1'b0;
  logic reset;

  always #5 clk_sys = ~clk_sys;

  cmos_nvram_arbiter_if bus ();

  cmos_nvram_arbiter dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  // Synchronous RAM, 1-cycle read latency, read-before-write
  logic [3:0] mem [0:1023] = '{default: 4'h0};
  always @(posedge clk_sys) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CPU-side vectors in idle state: the read result appears one cycle later
  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [3:0] din;
    logic       chk_rd;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int first;
    int wcount;
    int bad;
    int pause_fall;
    int seen_pause;
    int found;
    int stray;

    vecs[0] = '{1'b1, 10'h123, 4'hA, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 10'h123, 4'h0, 1'b1, 4'hA};
    vecs[2] = '{1'b1, 10'h3FF, 4'hC, 1'b0, 4'h0};
    vecs[3] = '{1'b1, 10'h000, 4'h3, 1'b0, 4'h0};
    vecs[4] = '{1'b0, 10'h3FF, 4'h5, 1'b1, 4'hC};
    vecs[5] = '{1'b0, 10'h000, 4'h0, 1'b1, 4'h3};
    vecs[6] = '{1'b1, 10'h055, 4'h6, 1'b0, 4'h0};
    vecs[7] = '{1'b0, 10'h055, 4'h0, 1'b1, 4'h6};

    reset              = 1'b1;
    bus.cpu_addr       = '0;
    bus.cpu_din        = '0;
    bus.cpu_we         = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_upload   = 1'b0;
    bus.ioctl_index    = '0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_rd       = 1'b0;
    bus.clear_req      = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk_sys);
    check("rst_cpu_pause", 32'(bus.cpu_pause), 0);
    check("rst_ioctl_wait", 32'(bus.ioctl_wait), 0);
    check("rst_ioctl_din", 32'(bus.ioctl_din), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ram_we", 32'(bus.ram_we), 0);
    reset = 1'b0;

    // ---------------- idle CPU access table ----------------
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      if (i > 0 && vecs[i-1].chk_rd)
        check($sformatf("cpu_rd_v%0d", i - 1), 32'(bus.cpu_dout), 32'(vecs[i-1].exp_rd));
      bus.cpu_we   = vecs[i].we;
      bus.cpu_addr = vecs[i].addr;
      bus.cpu_din  = vecs[i].din;
      #1;
      check($sformatf("cpu_ram_addr_v%0d", i), 32'(bus.ram_addr), 32'(vecs[i].addr));
      check($sformatf("cpu_ram_we_v%0d", i), 32'(bus.ram_we), 32'(vecs[i].we));
      if (vecs[i].we)
        check($sformatf("cpu_ram_din_v%0d", i), 32'(bus.ram_din), 32'(vecs[i].din));
      check($sformatf("cpu_busy_v%0d", i), 32'(bus.busy), 0);
    end
    @(negedge clk_sys);
    check("cpu_rd_v7", 32'(bus.cpu_dout), 32'(vecs[7].exp_rd));
    bus.cpu_we = 1'b0;

    // ---------------- NVRAM download ----------------
    @(negedge clk_sys);
    bus.ioctl_index    = 16'd4;
    bus.ioctl_download = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_sys);
      if (bus.ioctl_wait) n++;
      else if (n > 0) break;
    end
    check("dl_settle_cycles", 32'(n), 8);
    check("dl_cpu_pause", 32'(bus.cpu_pause), 1);
    check("dl_busy", 32'(bus.busy), 1);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0; bus.ioctl_dout = 8'h35;
    #1;
    check("dl_w0_we", 32'(bus.ram_we), 1);
    check("dl_w0_din", 32'(bus.ram_din), 5);
    check("dl_w0_addr", 32'(bus.ram_addr), 0);
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h1; bus.ioctl_dout = 8'h07;
    #1;
    check("dl_w1_din", 32'(bus.ram_din), 7);
    check("dl_w1_addr", 32'(bus.ram_addr), 1);
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h400; bus.ioctl_dout = 8'h0E;
    #1;
    check("dl_oor_we", 32'(bus.ram_we), 0);
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("dl_release_pause", 32'(bus.cpu_pause), 1);
    @(negedge clk_sys);
    check("dl_pause_fall", 32'(bus.cpu_pause), 0);
    check("dl_busy_fall", 32'(bus.busy), 0);
    check("dl_mem0", 32'(mem[0]), 5);
    check("dl_mem1", 32'(mem[1]), 7);

    // ---------------- NVRAM upload ----------------
    bus.ioctl_upload = 1'b1; bus.ioctl_addr = 25'h3FF;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_sys);
      if (bus.cpu_pause && !bus.ioctl_wait) begin found = 1; break; end
    end
    check("ul_reach_hps", 32'(found), 1);
    bus.ioctl_rd = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    check("ul_wait_high", 32'(bus.ioctl_wait), 1);
    @(negedge clk_sys);
    check("ul_wait_low", 32'(bus.ioctl_wait), 0);
    check("ul_din", 32'(bus.ioctl_din), 32'h0C);
    bus.ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("ul_done_busy", 32'(bus.busy), 0);

    // ---------------- non-NVRAM index ----------------
    bus.ioctl_index = 16'd0; bus.ioctl_download = 1'b1;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h2; bus.ioctl_dout = 8'h09;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_sys);
      if (bus.cpu_pause || bus.ram_we || bus.busy) stray++;
    end
    check("other_idx_stray", 32'(stray), 0);
    bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("other_idx_mem2", 32'(mem[2]), 0);

    // ---------------- full clear with a second edge mid-walk ----------------
    bus.clear_req = 1'b1;
    first = -1; wcount = 0; bad = 0; pause_fall = -1; seen_pause = 0;
    for (int s = 1; s <= 1100; s++) begin
      @(negedge clk_sys);
      if (bus.ram_we) begin
        if (first < 0) first = s;
        if (bus.ram_addr != 10'(s - first) || bus.ram_din != 4'hF) bad++;
        wcount++;
      end
      if (bus.cpu_pause) seen_pause = 1;
      else if (seen_pause && pause_fall < 0) pause_fall = s;
      if (s == 300) bus.clear_req = 1'b0;
      if (s == 500) bus.clear_req = 1'b1;
    end
    check("clr_first_write", 32'(first), 9);
    check("clr_write_count", 32'(wcount), 1024);
    check("clr_bad_writes", 32'(bad), 0);
    check("clr_pause_fall", 32'(pause_fall), 1034);
    check("clr_mem0", 32'(mem[0]), 32'hF);
    check("clr_mem1023", 32'(mem[1023]), 32'hF);

    // ---------------- simultaneous clear edge and HPS select ----------------
    bus.clear_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    bus.clear_req = 1'b1; bus.ioctl_index = 16'd4; bus.ioctl_download = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_sys);
      if (bus.ioctl_wait) n++;
      else if (n > 0) break;
    end
    check("both_settle_cycles", 32'(n), 8);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h5; bus.ioctl_dout = 8'h01;
    #1;
    check("both_hps_din", 32'(bus.ram_din), 1);
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (bus.busy || bus.ram_we) stray++;
    end
    check("both_clear_dropped", 32'(stray), 0);
    check("both_mem5", 32'(mem[5]), 1);

    // ---------------- reset in the middle of a clear ----------------
    bus.clear_req = 1'b0;
    bus.cpu_din   = 4'h2;
    bus.cpu_we    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      bus.cpu_addr = (k == 4) ? 10'h200 : 10'(98 + k);
    end
    @(negedge clk_sys);
    bus.cpu_we    = 1'b0;
    bus.clear_req = 1'b1;
    found = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk_sys);
      if (bus.ram_we && bus.ram_addr == 10'd100) begin found = 1; break; end
    end
    check("rstclr_reach_100", 32'(found), 1);
    reset = 1'b1; bus.clear_req = 1'b0;
    #1;
    check("rstclr_pause", 32'(bus.cpu_pause), 0);
    check("rstclr_busy", 32'(bus.busy), 0);
    check("rstclr_ram_we", 32'(bus.ram_we), 0);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rstclr_idle_busy", 32'(bus.busy), 0);
    check("rstclr_mem5", 32'(mem[5]), 32'hF);
    check("rstclr_mem98", 32'(mem[98]), 32'hF);
    check("rstclr_mem99", 32'(mem[99]), 32'hF);
    check("rstclr_mem100", 32'(mem[100]), 2);
    check("rstclr_mem101", 32'(mem[101]), 2);
    check("rstclr_mem200h", 32'(mem[10'h200]), 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
